// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches instruction words from instruction memory and buffers them in a
// 2-entry {pc, instruction} FIFO for the decoder. It keeps at most one request
// outstanding. A redirect flushes the FIFO and restarts fetch at a new pc.
//
// Handshakes:
//   imem side : a request completes in the cycle imem_req=1 && imem_ack=1.
//               imem_rdata is valid in that same cycle. imem_req and
//               imem_addr hold steady while the request waits for its ack.
//   decoder   : the head entry transfers when instr_valid=1 && instr_ready=1.
//               instr_valid only depends on FIFO occupancy, never on
//               instr_ready.
//
// Ports:
//   clk, reset_n           clock and asynchronous active-low reset
//   imem_req / imem_addr   read request and its word-aligned address
//   imem_ack / imem_rdata  request accepted / returned instruction word
//   redirect_valid/_pc     flush the pipeline and restart fetch at redirect_pc
//   instr_valid/_ready     decoder handshake for the FIFO head
//   instrCode / instr_pc   head instruction word and its address
//   state_dbg              current FSM state, for observation only
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instrCode,
    output logic [31:0] instr_pc,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        STALL   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;            // next address to fetch
    logic [31:0] discard_addr;  // address of the request being discarded
    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        push;
    logic        pop;
    logic [1:0]  count_after;
    logic [31:0] redirect_aligned;

    // Only a FETCH-state ack carries useful data. A redirect in the same
    // cycle makes that word stale.
    assign push = (state == FETCH) && imem_ack && !redirect_valid;
    assign pop  = instr_valid && instr_ready;

    assign count_after      = count + {1'b0, push} - {1'b0, pop};
    assign redirect_aligned = redirect_pc & ~32'h0000_0003;

    // While discarding, the old request is still on the bus. pc already holds
    // the redirect target, so the address comes from discard_addr instead.
    assign imem_req    = (state == FETCH) || (state == DISCARD);
    assign imem_addr   = (state == DISCARD) ? discard_addr : pc;
    assign instr_valid = (count != 2'd0);
    assign instrCode   = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
    assign state_dbg   = state;

    // FIFO storage and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= 32'h0;
                fifo_instr[i] <= 32'h0;
            end
        end else if (redirect_valid) begin
            // A pop in this cycle has already transferred the head.
            // Everything else is flushed.
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= pc;
                fifo_instr[wr_ptr] <= imem_rdata;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_after;
        end
    end

    // Fetch FSM and fetch pc
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            discard_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (redirect_valid) begin
                        pc <= redirect_aligned;
                    end
                end
                FETCH: begin
                    if (redirect_valid) begin
                        pc <= redirect_aligned;
                        if (!imem_ack) begin
                            // The old request must still finish.
                            // Remember its address and drop its data.
                            state        <= DISCARD;
                            discard_addr <= pc;
                        end
                    end else if (imem_ack) begin
                        pc <= pc + 32'd4;
                        if (count_after == 2'd2) begin
                            state <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (redirect_valid) begin
                        pc    <= redirect_aligned;
                        state <= FETCH;
                    end else if (count_after < 2'd2) begin
                        state <= FETCH;
                    end
                end
                DISCARD: begin
                    if (redirect_valid) begin
                        pc <= redirect_aligned;
                    end
                    if (imem_ack) begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
